booth_r4_seq_mult: RTL



---
 rtl/booth_r4_seq_mult.sv | 125 ++++++++++++
 1 files changed

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - iterative radix-4 Booth multiplier, one digit retired per clock
// Define BOOTH_SKIP_ZERO_EN to finish early once the remaining multiplier digits are all zero.
module booth_r4_seq_mult #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int              PW   = 2*WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    m_q, m_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH:0]   qx_q, qx_d;

  logic [CNT_W:0]   shift;
  logic [2:0]       grp;
  logic             dig_valid, dig_twice, dig_neg;
  logic [PW-1:0]    base, addend, acc_sum;
  logic             last_digit;

  // Booth digit datapath; negation is invert plus carry-in so -2^(W-1) operands stay exact.
  always_comb begin
    shift     = {cnt_q, 1'b0};
    grp       = 3'(qx_q >> shift);
    dig_valid = (grp != 3'b000) && (grp != 3'b111);
    dig_twice = (grp == 3'b011) || (grp == 3'b100);
    dig_neg   = grp[2] && dig_valid;
    base      = dig_twice ? (m_q << 1) : m_q;
    addend    = dig_valid ? (base << shift) : '0;
    acc_sum   = acc_q + (addend ^ {PW{dig_neg}}) + PW'(dig_neg);
  end

`ifdef BOOTH_SKIP_ZERO_EN
  logic [CNT_W:0] shift_hi;
  logic [WIDTH:0] q_rem;

  // Upper bits that are pure sign extension decode to zero digits only.
  always_comb begin
    shift_hi   = shift + (CNT_W+1)'(2);
    q_rem      = $signed(qx_q) >>> shift_hi;
    last_digit = (cnt_q == LAST) || (q_rem == '0) || (q_rem == '1);
  end
`else
  assign last_digit = (cnt_q == LAST);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    m_d       = m_q;
    qx_d      = qx_q;
    prod_d    = prod_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          m_d     = {{WIDTH{multiplicand[WIDTH-1]}}, multiplicand};
          qx_d    = {multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_digit) begin
          prod_d  = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      qx_q    <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      qx_q    <= qx_d;
      prod_q  <= prod_d;
    end
  end

  assign product = prod_q;

endmodule
